// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for a 5-stage pipeline.
// Ports: clk; rst (async, active-low); id_r2/id_r3/id_use_r2/id_use_r3 (decode sources);
// ex_dest/ex_rmem/ex_wreg (EX producer); jump_en (taken jump in EX);
// mem_req/mem_ack (MEM handshake); pc_en, if_id_en/flush, id_ex_en/flush, ex_mem_en,
// mem_wb_bubble (pipeline controls); bus_err (sticky timeout); stall_cycles (saturating).
module pipeline_hazard_controller #(
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_r2,
    input  logic [REG_W-1:0] id_r3,
    input  logic             id_use_r2,
    input  logic             id_use_r3,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             ex_rmem,
    input  logic             ex_wreg,
    input  logic             jump_en,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_bubble,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int WC_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t          state, state_nx;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nx;
    logic            mem_stall, load_use;

    assign mem_stall = mem_req & ~mem_ack;
    assign load_use  = ex_rmem & ex_wreg &
                       ((id_use_r2 & (id_r2 == ex_dest)) | (id_use_r3 & (id_r3 == ex_dest)));

    // A memory stall freezes every stage, so it looks the same as ERR on the outputs.
    always_comb begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b1111;
        {if_id_flush, id_ex_flush, mem_wb_bubble} = 3'b000;
        if (state == ERR || mem_stall) begin
            {pc_en, if_id_en, id_ex_en, ex_mem_en} = 4'b0000;
            mem_wb_bubble = 1'b1;
        end else if (jump_en) begin
            {if_id_flush, id_ex_flush} = 2'b11;
        end else if (load_use) begin
            {pc_en, if_id_en} = 2'b00;
            id_ex_flush = 1'b1;
        end
    end

    // Dropping mem_req while waiting releases the freeze just like an ack.
    always_comb begin
        state_nx    = state;
        wait_cnt_nx = wait_cnt;
        if (state == RUN && mem_stall) begin
            state_nx    = MEM_WAIT;
            wait_cnt_nx = WC_W'(1);
        end else if (state == MEM_WAIT) begin
            if (!mem_stall) begin
                state_nx    = RUN;
                wait_cnt_nx = '0;
            end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
                state_nx = ERR;
            end else begin
                wait_cnt_nx = wait_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            bus_err      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            bus_err  <= bus_err | (state_nx == ERR);
            if (!pc_en && !(&stall_cycles))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage CPU pipeline (fetch, decode, EX, MEM, WB).
- Detects load-use hazards between decode and EX and resolves them with a one-cycle bubble.
- Squashes wrong-path instructions when EX resolves a taken jump.
- Freezes the whole pipeline while the memory controller has not acknowledged a MEM-stage access, with a timeout watchdog.
- Drives the enable/flush inputs of the PC register and the three pipeline registers, and keeps a stall-cycle performance counter.

Parameters:
REG_W, 4, register-index width (16 registers)
TIMEOUT, 16, max consecutive unacknowledged memory cycles before bus error (>=2)
CNT_W, 16, width of the stall performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
id_r2  in  REG_W  decode-stage source register R2
id_r3  in  REG_W  decode-stage source register R3
id_use_r2  in  1  decode instruction reads R2
id_use_r3  in  1  decode instruction reads R3 (0 when immediate flag set)
ex_dest  in  REG_W  EX-stage destination register
ex_rmem  in  1  EX-stage instruction is a memory read
ex_wreg  in  1  EX-stage instruction writes the register file
jump_en  in  1  taken jump resolved in EX this cycle
mem_req  in  1  MEM-stage instruction accesses memory (Wmem|Rmem)
mem_ack  in  1  memory controller completes access this cycle
pc_en  out  1  PC register load enable
if_id_en  out  1  fetch->decode register enable
if_id_flush  out  1  fetch->decode register clear
id_ex_en  out  1  decode->EX register enable
id_ex_flush  out  1  decode->EX register clear (insert bubble)
ex_mem_en  out  1  EX->MEM register enable
mem_wb_bubble  out  1  MEM->WB register loads a bubble (Wreg=0)
bus_err  out  1  sticky memory-timeout error
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- States: RUN, MEM_WAIT, ERR. Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, stall_cycles=0, bus_err=0.
- Outputs are combinational from the current state and inputs. Reset-time values: pc_en=if_id_en=id_ex_en=ex_mem_en=1, all flush/bubble=0.
- Conditions:
  - mem_stall = mem_req & !mem_ack.
  - load_use = ex_rmem & ex_wreg & ((id_use_r2 & id_r2==ex_dest) | (id_use_r3 & id_r3==ex_dest)).
  - Register 0 is not special.
- Priority, highest first: ERR > mem_stall > jump_en > load_use > normal.
  - ERR: all enables 0, flushes 0, mem_wb_bubble=1. The pipeline is frozen until reset.
  - mem_stall: pc_en=if_id_en=id_ex_en=ex_mem_en=0, mem_wb_bubble=1, flushes 0.
    - jump_en and load_use are ignored this cycle.
    - EX holds, so jump_en and load_use persist and take effect on the release cycle.
  - jump_en: all enables 1, if_id_flush=1, id_ex_flush=1. The PC loads the jump target via the existing PC mux. A simultaneous load_use is discarded, because its instruction is squashed.
  - load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. One bubble; the next cycle re-evaluates with the load now in MEM.
  - normal: all enables 1, no flush, no bubble.
- Transitions:
  - RUN -> MEM_WAIT when mem_stall; wait_cnt <= 1.
  - MEM_WAIT -> RUN when mem_ack; wait_cnt <= 0. The ack cycle is not stalled.
  - MEM_WAIT -> RUN when mem_req drops; this is a protocol anomaly, treated like an ack.
  - MEM_WAIT: if mem_stall and wait_cnt == TIMEOUT-1, go to ERR and set bus_err <= 1. Otherwise wait_cnt increments.
- Zero-wait access (mem_req & mem_ack in the same cycle): no stall, stays RUN.
- stall_cycles increments every cycle pc_en==0, including load-use and ERR cycles. It saturates at all-ones and never wraps.
- Reset asserted in any state, including mid-wait or ERR, immediately returns to RUN and clears bus_err and both counters.

Test Plan:
1. Reset, then idle with no hazards for 5 cycles -> all enables 1, no flushes, stall_cycles=0, bus_err=0.
2. Load-use: ex_rmem=1, ex_wreg=1, ex_dest=5, id_r2=5, id_use_r2=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles=1 afterwards. Repeat with id_use_r2=0 -> no stall.
3. jump_en=1 together with load_use -> if_id_flush=id_ex_flush=1, pc_en=1, stall_cycles unchanged.
4. mem_req=1, mem_ack=0 for 3 cycles then mem_ack=1 -> 3 frozen cycles with mem_wb_bubble=1, advance on the ack cycle, stall_cycles=3, state back to RUN. With jump_en held high throughout, the flush occurs only on the ack cycle.
5. mem_req=1, mem_ack never asserted, TIMEOUT=16 -> bus_err rises after 16 stalled cycles and stays high with the pipeline frozen. Drive rst=0 mid-ERR -> bus_err=0, stall_cycles=0 immediately, without waiting for a clock edge.
6. CNT_W=4 with 20 stall cycles -> stall_cycles saturates at 15.
